// File: rtl/sorted_block_unpacker.sv
// Block FIFO plus serializer for the bitonic sorter. Sorted blocks arrive whole
// and leave one record per cycle on a valid/ready stream, smallest key first.
module sorted_block_unpacker #(
    parameter int P_LOG      = 4,
    parameter int DATW       = 64,
    parameter int KEYW       = 32,
    parameter int FDEPTH_LOG = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [(DATW<<P_LOG)-1:0]    DIN,
    input  logic                        DINEN,
    output logic [DATW-1:0]             DOT,
    output logic                        DOTEN,
    input  logic                        DOTRDY,
    output logic                        BLKLAST,
    output logic [FDEPTH_LOG:0]         FCNT,
    output logic                        FULL,
    output logic                        OVF,
    output logic                        ORDERR
);
    localparam int BLKW  = DATW << P_LOG;
    localparam int DEPTH = 1 << FDEPTH_LOG;
    localparam logic [FDEPTH_LOG:0] DEPTH_C  = (FDEPTH_LOG+1)'(DEPTH);
    localparam logic [P_LOG-1:0]    LAST_IDX = {P_LOG{1'b1}};

    typedef enum logic {IDLE, EMIT} state_t;

    logic [BLKW-1:0]       r_mem [DEPTH];
    logic [FDEPTH_LOG-1:0] r_wptr, r_rptr;
    logic [FDEPTH_LOG:0]   r_fcnt;
    logic [BLKW-1:0]       r_blk;
    logic [P_LOG-1:0]      r_idx;
    state_t                r_state;
    logic [KEYW-1:0]       r_prev_key;
    logic                  r_ovf, r_orderr;

    logic                  w_fifo_ne, w_last, w_xfer, w_pop, w_wr;
    logic [DATW-1:0]       w_dot;
    logic [KEYW-1:0]       w_key;

    always_comb begin
        w_fifo_ne = (r_fcnt != '0);
        w_last    = (r_idx == LAST_IDX);
        w_xfer    = (r_state == EMIT) && DOTRDY;
        // Pop when idle, or when the last record of the current block leaves.
        w_pop     = w_fifo_ne && ((r_state == IDLE) || (w_xfer && w_last));
        w_wr      = DINEN && ((r_fcnt != DEPTH_C) || w_pop);
        w_dot     = r_blk[int'(r_idx)*DATW +: DATW];
        w_key     = w_dot[KEYW-1:0];
    end

    // Storage is not reset; pointers and FCNT define what is valid.
    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wptr] <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fcnt     <= '0;
            r_blk      <= '0;
            r_idx      <= '0;
            r_state    <= IDLE;
            r_prev_key <= '0;
            r_ovf      <= 1'b0;
            r_orderr   <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (DINEN && !w_wr) r_ovf <= 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_blk  <= r_mem[r_rptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_xfer) begin
                r_prev_key <= w_key;
                if (r_idx != '0 && w_key < r_prev_key) r_orderr <= 1'b1;
            end
            case (r_state)
                IDLE: if (w_fifo_ne) begin
                    r_state <= EMIT;
                    r_idx   <= '0;
                end
                EMIT: if (w_xfer) begin
                    if (!w_last)        r_idx   <= r_idx + 1'b1;
                    else if (w_fifo_ne) r_idx   <= '0;
                    else                r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DOT     = w_dot;
    assign DOTEN   = (r_state == EMIT);
    assign BLKLAST = (r_state == EMIT) && w_last;
    assign FCNT    = r_fcnt;
    assign FULL    = (r_fcnt == DEPTH_C);
    assign OVF     = r_ovf;
    assign ORDERR  = r_orderr;
endmodule

// File: tb/tb_sorted_block_unpacker.sv
// Directed bench for sorted_block_unpacker: stimulus pushes expected records,
// a negedge monitor pops and compares every transfer.
module tb_sorted_block_unpacker;
    localparam int P_LOG = 4, N = 16, DATW = 64, KEYW = 32, FDL = 2;
    localparam int BLKW = DATW * N;

    logic            CLK = 1'b0;
    logic            RST, DINEN, DOTRDY;
    logic [BLKW-1:0] DIN;
    logic [DATW-1:0] DOT;
    logic            DOTEN, BLKLAST, FULL, OVF, ORDERR;
    logic [FDL:0]    FCNT;

    sorted_block_unpacker #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .FDEPTH_LOG(FDL)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DINEN(DINEN), .DOT(DOT), .DOTEN(DOTEN),
        .DOTRDY(DOTRDY), .BLKLAST(BLKLAST), .FCNT(FCNT), .FULL(FULL), .OVF(OVF), .ORDERR(ORDERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        first;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, xfer_cnt = 0, first_cyc = 0, last_cyc = 0;
    logic        exp_orderr = 1'b0;
    logic [31:0] exp_prev = '0;
    logic        prev_stall = 1'b0, prev_cont = 1'b0, prev_bl = 1'b0;
    logic [63:0] prev_dot = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge sees the values the next edge uses.
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (RST) begin
            sbq.delete();
            exp_orderr = 1'b0;
            prev_stall = 1'b0;
            prev_cont  = 1'b0;
        end else begin
            chk("orderr", ORDERR, exp_orderr);
            if (prev_stall) begin
                chk("stall_doten", DOTEN, 1);
                chk("stall_dot", DOT, prev_dot);
                chk("stall_blklast", BLKLAST, prev_bl);
            end
            if (prev_cont) chk("midblock_doten", DOTEN, 1);
            prev_stall = DOTEN && !DOTRDY;
            prev_dot   = DOT;
            prev_bl    = BLKLAST;
            prev_cont  = 1'b0;
            if (DOTEN && DOTRDY) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer got %0h expected none", DOT);
                end else begin
                    e = sbq.pop_front();
                    chk("dot", DOT, e.data);
                    chk("blklast", BLKLAST, e.last);
                    if (!e.first && e.data[31:0] < exp_prev) exp_orderr = 1'b1;
                    exp_prev  = e.data[31:0];
                    prev_cont = !e.last;
                end
                xfer_cnt++;
                if (xfer_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    // kind 0: keys base+i; 1: 0,1,2,9,3..14; 2: base+i/2 (equal neighbours)
    task automatic send_blk(input int tag, input int base, input int kind, input bit accept);
        logic [31:0] key;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            case (kind)
                1:       key = (i < 3) ? i : (i == 3) ? 9 : i - 1;
                2:       key = base + i / 2;
                default: key = base + i;
            endcase
            DIN[i*DATW +: DATW] = {tag[31:0], key};
            if (accept) begin
                e.data  = {tag[31:0], key};
                e.last  = (i == N - 1);
                e.first = (i == 0);
                sbq.push_back(e);
            end
        end
        DINEN = 1'b1;
        @(posedge CLK); #1;
    endtask

    // mode 0: DOTRDY=1; mode 1: DOTRDY pattern 1,0,0,1
    task automatic drain(input int mode, input int bound);
        int k = 0;
        while (sbq.size() > 0 && k < bound) begin
            DOTRDY = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            @(posedge CLK); #1;
            k++;
        end
        if (sbq.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d left expected 0", sbq.size());
        end
        DOTRDY = 1'b1;
        @(posedge CLK); #1;
        chk("idle_doten", DOTEN, 0);
        chk("idle_fcnt", FCNT, 0);
    endtask

    initial begin
        int k;
        RST = 1'b1; DINEN = 1'b0; DOTRDY = 1'b1; DIN = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_doten", DOTEN, 0);
        chk("rst_fcnt", FCNT, 0);
        chk("rst_full", FULL, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_orderr", ORDERR, 0);
        chk("rst_dot", DOT, 0);
        chk("rst_blklast", BLKLAST, 0);

        // single block, latency and 16 back-to-back records
        xfer_cnt = 0;
        send_blk(1, 0, 0, 1);
        DINEN = 1'b0;
        chk("t1_fcnt_e0", FCNT, 1);
        chk("t1_doten_e0", DOTEN, 0);
        @(posedge CLK); #1;
        chk("t1_doten_e1", DOTEN, 1);
        chk("t1_dot_e1", DOT, {32'd1, 32'd0});
        chk("t1_fcnt_e1", FCNT, 0);
        drain(0, 100);
        chk("t1_count", xfer_cnt, 16);
        chk("t1_span", last_cyc - first_cyc, 15);
        chk("t1_orderr", ORDERR, 0);

        // two blocks back to back, no bubble across the boundary
        xfer_cnt = 0;
        send_blk(2, 0, 0, 1);
        send_blk(3, 100, 0, 1);
        DINEN = 1'b0;
        drain(0, 100);
        chk("t2_count", xfer_cnt, 32);
        chk("t2_span", last_cyc - first_cyc, 31);
        chk("t2_orderr", ORDERR, 0);

        // backpressure, with equal neighbouring keys
        xfer_cnt = 0;
        send_blk(4, 50, 2, 1);
        DINEN = 1'b0;
        drain(1, 200);
        chk("t3_count", xfer_cnt, 16);
        chk("t3_orderr", ORDERR, 0);

        // overflow: DEPTH+1 blocks fit, sixth is dropped
        xfer_cnt = 0;
        DOTRDY = 1'b0;
        for (int b = 0; b < 6; b++) begin
            send_blk(10 + b, 16 * b, 0, b < 5);
            if (b == 4) chk("t4_ovf_before", OVF, 0);
        end
        DINEN = 1'b0;
        chk("t4_fcnt", FCNT, 4);
        chk("t4_full", FULL, 1);
        chk("t4_ovf", OVF, 1);
        repeat (2) @(posedge CLK);
        #1;
        drain(0, 300);
        chk("t4_count", xfer_cnt, 80);
        chk("t4_ovf_sticky", OVF, 1);
        chk("t4_full_after", FULL, 0);

        // intra-block key decrease
        xfer_cnt = 0;
        send_blk(20, 0, 1, 1);
        DINEN = 1'b0;
        drain(0, 100);
        chk("t5_count", xfer_cnt, 16);
        chk("t5_orderr", ORDERR, 1);

        // reset mid-block with a second block queued
        xfer_cnt = 0;
        send_blk(30, 200, 0, 1);
        send_blk(31, 300, 0, 1);
        DINEN = 1'b0;
        k = 0;
        while (xfer_cnt < 5 && k < 100) begin
            @(posedge CLK); #1;
            k++;
        end
        chk("t6_reached5", xfer_cnt, 5);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("t6_doten", DOTEN, 0);
        chk("t6_fcnt", FCNT, 0);
        chk("t6_ovf", OVF, 0);
        chk("t6_orderr", ORDERR, 0);
        chk("t6_blklast", BLKLAST, 0);
        xfer_cnt = 0;
        send_blk(32, 500, 0, 1);
        DINEN = 1'b0;
        chk("t6_fcnt_e0", FCNT, 1);
        @(posedge CLK); #1;
        chk("t6_doten_e1", DOTEN, 1);
        chk("t6_dot_e1", DOT, {32'd32, 32'd500});
        drain(0, 100);
        chk("t6_count", xfer_cnt, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
